// File: rtl/execute_stage_core.sv
// Decode/Execute pipeline register plus execute-stage datapath.
// Latches the decode control bundle, scalar/vector operands and register
// indices, forwards operands from WB/MEM, and computes the 8-bit scalar
// ALU result and the 16-lane x 8-bit vector ALU result.
module execute_stage_core (
  input  logic         clk,
  input  logic         reset,
  input  logic [19:0]  nop_mux_output_in,
  input  logic [15:0]  srcA_in,
  input  logic [15:0]  srcB_in,
  input  logic [127:0] srcA_vector_in,
  input  logic [127:0] srcB_vector_in,
  input  logic [4:0]   rs1_decode,
  input  logic [4:0]   rs2_decode,
  input  logic [4:0]   rd_decode,
  input  logic [2:0]   select_forward_mux_A,
  input  logic [2:0]   select_forward_mux_B,
  input  logic [15:0]  writeback_data,
  input  logic [7:0]   alu_result_memory,
  input  logic [127:0] writeback_vector,
  input  logic [127:0] alu_vector_result_memory,
  output logic         wre_execute,
  output logic         vector_wre_execute,
  output logic         write_memory_enable_a_execute,
  output logic         write_memory_enable_b_execute,
  output logic [1:0]   select_writeback_data_mux_execute,
  output logic [1:0]   select_writeback_vector_data_mux_execute,
  output logic [4:0]   aluOp_execute,
  output logic [4:0]   aluVectorOp_execute,
  output logic         load_instruction,
  output logic [15:0]  srcA_out,
  output logic [15:0]  srcB_out,
  output logic [127:0] srcA_vector_out,
  output logic [127:0] srcB_vector_out,
  output logic [4:0]   rs1_execute,
  output logic [4:0]   rs2_execute,
  output logic [4:0]   rd_execute,
  output logic [15:0]  alu_src_B,
  output logic [7:0]   alu_result_execute,
  output logic [127:0] alu_vector_result_execute
);

  // Bit 0 of the bundle is reserved and intentionally not latched.
  logic unused_reserved_bit;
  assign unused_reserved_bit = nop_mux_output_in[0];

  logic [18:0]  ctrl_q, ctrl_d;
  logic [15:0]  srca_q, srca_d, srcb_q, srcb_d;
  logic [127:0] vec_a_q, vec_a_d, vec_b_q, vec_b_d;
  logic [14:0]  idx_q, idx_d;

  assign ctrl_d  = nop_mux_output_in[19:1];
  assign srca_d  = srcA_in;
  assign srcb_d  = srcB_in;
  assign vec_a_d = srcA_vector_in;
  assign vec_b_d = srcB_vector_in;
  assign idx_d   = {rs1_decode, rs2_decode, rd_decode};

  // Pipeline register: 1-cycle latency, synchronous clear (no stall input).
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q  <= '0;
      srca_q  <= '0;
      srcb_q  <= '0;
      vec_a_q <= '0;
      vec_b_q <= '0;
      idx_q   <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      srca_q  <= srca_d;
      srcb_q  <= srcb_d;
      vec_a_q <= vec_a_d;
      vec_b_q <= vec_b_d;
      idx_q   <= idx_d;
    end
  end

  assign {wre_execute, vector_wre_execute,
          write_memory_enable_a_execute, write_memory_enable_b_execute,
          select_writeback_data_mux_execute,
          select_writeback_vector_data_mux_execute,
          aluOp_execute, aluVectorOp_execute, load_instruction} = ctrl_q;

  assign srcA_out        = srca_q;
  assign srcB_out        = srcb_q;
  assign srcA_vector_out = vec_a_q;
  assign srcB_vector_out = vec_b_q;
  assign {rs1_execute, rs2_execute, rd_execute} = idx_q;

  // Shared 8-bit ALU slice used by the scalar path and every vector lane.
  function automatic logic [7:0] alu8(input logic [4:0] op,
                                      input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] r;
    case (op)
      5'd0:    r = a + b;
      5'd1:    r = a - b;
      5'd2:    r = a & b;
      5'd3:    r = a | b;
      5'd4:    r = a ^ b;
      5'd5:    r = a << b[2:0];
      5'd6:    r = a >> b[2:0];
      5'd7:    r = a;
      5'd8:    r = b;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  logic [15:0]  fwd_a, fwd_b;
  logic [127:0] fwd_va, fwd_vb;

  // Operand forwarding: 1 = writeback stage, 2 = memory stage, else register.
  always_comb begin
    fwd_a  = srca_q;
    fwd_b  = srcb_q;
    fwd_va = vec_a_q;
    fwd_vb = vec_b_q;
    case (select_forward_mux_A)
      3'd1:    begin fwd_a = writeback_data;             fwd_va = writeback_vector;         end
      3'd2:    begin fwd_a = {8'h00, alu_result_memory}; fwd_va = alu_vector_result_memory; end
      default: ;
    endcase
    case (select_forward_mux_B)
      3'd1:    begin fwd_b = writeback_data;             fwd_vb = writeback_vector;         end
      3'd2:    begin fwd_b = {8'h00, alu_result_memory}; fwd_vb = alu_vector_result_memory; end
      default: ;
    endcase
  end

  assign alu_src_B          = fwd_b;
  assign alu_result_execute = alu8(aluOp_execute, fwd_a[7:0], fwd_b[7:0]);

  // Vector ALU: independent lanes, no carry/borrow or shift across lanes.
  always_comb begin
    alu_vector_result_execute = '0;
    for (int i = 0; i < 16; i++) begin
      alu_vector_result_execute[8*i +: 8] =
        alu8(aluVectorOp_execute, fwd_va[8*i +: 8], fwd_vb[8*i +: 8]);
    end
  end

endmodule

// File: tb/tb_execute_stage_core.sv
// Self-checking bench for execute_stage_core with a behavioural reference model.
module tb_execute_stage_core;

  logic         clk = 1'b0;
  logic         reset;
  logic [19:0]  bundle;
  logic [15:0]  srcA, srcB, wb;
  logic [127:0] vA, vB, wbv, memv;
  logic [4:0]   rs1, rs2, rd;
  logic [2:0]   selA, selB;
  logic [7:0]   mem;

  logic         wre_e, vwre_e, wme_a_e, wme_b_e, load_e;
  logic [1:0]   selwb_e, selwbv_e;
  logic [4:0]   aluop_e, aluvop_e, rs1_e, rs2_e, rd_e;
  logic [15:0]  srcA_o, srcB_o, alu_src_B;
  logic [127:0] vA_o, vB_o, valu;
  logic [7:0]   alu;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  execute_stage_core dut (
    .clk(clk), .reset(reset), .nop_mux_output_in(bundle),
    .srcA_in(srcA), .srcB_in(srcB), .srcA_vector_in(vA), .srcB_vector_in(vB),
    .rs1_decode(rs1), .rs2_decode(rs2), .rd_decode(rd),
    .select_forward_mux_A(selA), .select_forward_mux_B(selB),
    .writeback_data(wb), .alu_result_memory(mem),
    .writeback_vector(wbv), .alu_vector_result_memory(memv),
    .wre_execute(wre_e), .vector_wre_execute(vwre_e),
    .write_memory_enable_a_execute(wme_a_e), .write_memory_enable_b_execute(wme_b_e),
    .select_writeback_data_mux_execute(selwb_e),
    .select_writeback_vector_data_mux_execute(selwbv_e),
    .aluOp_execute(aluop_e), .aluVectorOp_execute(aluvop_e),
    .load_instruction(load_e),
    .srcA_out(srcA_o), .srcB_out(srcB_o),
    .srcA_vector_out(vA_o), .srcB_vector_out(vB_o),
    .rs1_execute(rs1_e), .rs2_execute(rs2_e), .rd_execute(rd_e),
    .alu_src_B(alu_src_B), .alu_result_execute(alu),
    .alu_vector_result_execute(valu)
  );

  logic [18:0] obs_ctrl;
  logic [14:0] obs_idx;
  assign obs_ctrl = {wre_e, vwre_e, wme_a_e, wme_b_e, selwb_e, selwbv_e,
                     aluop_e, aluvop_e, load_e};
  assign obs_idx  = {rs1_e, rs2_e, rd_e};

  // Reference model: what the execute register should be holding.
  logic [19:0]  m_bundle;
  logic [15:0]  m_srcA, m_srcB;
  logic [127:0] m_vA, m_vB;
  logic [14:0]  m_idx;

  function automatic logic [7:0] ref_alu(input int op, input int a, input int b);
    int r;
    case (op)
      0: r = (a + b) % 256;
      1: r = (a - b + 256) % 256;
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (a * (1 << (b % 8))) % 256;
      6: r = a / (1 << (b % 8));
      7: r = a;
      8: r = b;
      default: r = 0;
    endcase
    return r[7:0];
  endfunction

  function automatic logic [15:0] ref_fwd(input logic [2:0] sel, input logic [15:0] r,
                                          input logic [15:0] w, input logic [7:0] m);
    if (sel == 3'd1) return w;
    if (sel == 3'd2) return {8'h00, m};
    return r;
  endfunction

  function automatic logic [127:0] ref_fwdv(input logic [2:0] sel, input logic [127:0] r,
                                            input logic [127:0] w, input logic [127:0] m);
    if (sel == 3'd1) return w;
    if (sel == 3'd2) return m;
    return r;
  endfunction

  function automatic logic [7:0] exp_alu();
    logic [15:0] a, b;
    a = ref_fwd(selA, m_srcA, wb, mem);
    b = ref_fwd(selB, m_srcB, wb, mem);
    return ref_alu(int'(m_bundle[11:7]), int'(a[7:0]), int'(b[7:0]));
  endfunction

  function automatic logic [127:0] exp_valu();
    logic [127:0] a, b, r;
    a = ref_fwdv(selA, m_vA, wbv, memv);
    b = ref_fwdv(selB, m_vB, wbv, memv);
    r = '0;
    for (int l = 0; l < 16; l++)
      r[8*l +: 8] = ref_alu(int'(m_bundle[6:2]), int'(a[8*l +: 8]), int'(b[8*l +: 8]));
    return r;
  endfunction

  task automatic zero_inputs();
    bundle = '0; srcA = '0; srcB = '0; vA = '0; vB = '0;
    rs1 = '0; rs2 = '0; rd = '0; selA = '0; selB = '0;
    wb = '0; mem = '0; wbv = '0; memv = '0;
  endtask

  // One clock edge; the model captures the decode inputs (or clears on reset).
  task automatic step();
    @(posedge clk);
    if (reset) begin
      m_bundle = '0; m_srcA = '0; m_srcB = '0; m_vA = '0; m_vB = '0; m_idx = '0;
    end else begin
      m_bundle = bundle; m_srcA = srcA; m_srcB = srcB; m_vA = vA; m_vB = vB;
      m_idx = {rs1, rs2, rd};
    end
    #1;
  endtask

  task automatic test_reset();
    zero_inputs();
    bundle = 20'hABCDE; srcA = 16'h1234; vA = {16{8'h5A}}; rd = 5'd9;
    reset = 1'b1;
    step();
    checks++; if (obs_ctrl !== 19'h0) begin errors++; $display("FAIL reset_ctrl got=%h exp=0", obs_ctrl); end
    checks++; if (srcA_o !== 16'h0 || vA_o !== 128'h0 || obs_idx !== 15'h0) begin errors++; $display("FAIL reset_ops got=%h/%h/%h exp=0", srcA_o, vA_o, obs_idx); end
    reset = 1'b0;
    zero_inputs();
    step();
    checks++; if ({obs_ctrl, srcA_o, srcB_o, obs_idx} !== '0 || vA_o !== '0 || vB_o !== '0) begin errors++; $display("FAIL reset_regs got=%h exp=0", {obs_ctrl, srcA_o, srcB_o, obs_idx}); end
    checks++; if (alu !== 8'h00 || valu !== 128'h0 || alu_src_B !== 16'h0) begin errors++; $display("FAIL reset_alu got=%h/%h/%h exp=0", alu, valu, alu_src_B); end
  endtask

  task automatic test_basic();
    zero_inputs();
    srcA = 16'd1; srcB = 16'd2; vA = 128'd1; vB = 128'd1; rs1 = 5'd1; rs2 = 5'd2; rd = 5'd3;
    step();
    checks++; if (srcA_o !== 16'd1 || srcB_o !== 16'd2 || rd_e !== 5'd3) begin errors++; $display("FAIL basic_regs got=%h/%h/%h exp=1/2/3", srcA_o, srcB_o, rd_e); end
    checks++; if (alu !== 8'd3) begin errors++; $display("FAIL basic_alu got=%h exp=03", alu); end
    checks++; if (valu !== 128'h2) begin errors++; $display("FAIL basic_valu got=%h exp=2", valu); end
    checks++; if (alu_src_B !== 16'd2) begin errors++; $display("FAIL basic_srcB got=%h exp=0002", alu_src_B); end
  endtask

  task automatic test_wrap();
    zero_inputs();
    bundle = 20'(1 << 7);
    srcA = 16'h0005; srcB = 16'h0007; vA = {16{8'hFF}}; vB = {16{8'h01}};
    step();
    checks++; if (alu !== 8'hFE) begin errors++; $display("FAIL sub_wrap got=%h exp=fe", alu); end
    checks++; if (valu !== 128'h0) begin errors++; $display("FAIL vadd_lane_carry got=%h exp=0", valu); end
    vA = 128'h00FF; vB = 128'h0001;
    step();
    checks++; if (valu !== 128'h0) begin errors++; $display("FAIL vadd_single_lane got=%h exp=0", valu); end
  endtask

  task automatic test_forward();
    zero_inputs();
    srcA = 16'd1; srcB = 16'd2;
    step();
    selA = 3'd2; mem = 8'h10;
    #1;
    checks++; if (alu !== 8'h12) begin errors++; $display("FAIL fwd_mem_A got=%h exp=12", alu); end
    selB = 3'd1; wb = 16'h0040;
    #1;
    checks++; if (alu_src_B !== 16'h0040) begin errors++; $display("FAIL fwd_wb_B got=%h exp=0040", alu_src_B); end
    checks++; if (alu !== 8'h50) begin errors++; $display("FAIL fwd_both got=%h exp=50", alu); end
    selA = 3'd5; selB = 3'd7;
    #1;
    checks++; if (alu !== 8'h03 || alu_src_B !== 16'h0002) begin errors++; $display("FAIL fwd_sel_hi got=%h/%h exp=03/0002", alu, alu_src_B); end
  endtask

  task automatic test_ones_then_reset();
    zero_inputs();
    bundle = 20'hFFFFE; srcA = 16'hBEEF; vA = {16{8'h33}}; rd = 5'd31;
    step();
    checks++; if (obs_ctrl !== 19'h7FFFF) begin errors++; $display("FAIL ones_ctrl got=%h exp=7ffff", obs_ctrl); end
    checks++; if (alu !== 8'h00 || valu !== 128'h0) begin errors++; $display("FAIL ones_alu got=%h/%h exp=0", alu, valu); end
    reset = 1'b1;
    step();
    checks++; if ({obs_ctrl, srcA_o, srcB_o, obs_idx} !== '0 || vA_o !== '0 || vB_o !== '0) begin errors++; $display("FAIL midreset_regs got=%h exp=0", {obs_ctrl, srcA_o, obs_idx}); end
    checks++; if (alu !== 8'h00 || valu !== 128'h0 || alu_src_B !== 16'h0) begin errors++; $display("FAIL midreset_alu got=%h/%h/%h exp=0", alu, valu, alu_src_B); end
    reset = 1'b0;
  endtask

  task automatic test_shift();
    zero_inputs();
    bundle = 20'((6 << 7) | (5 << 2));
    srcA = 16'h0080; srcB = 16'h000B; vA = {16{8'h81}}; vB = {16{8'h01}};
    step();
    checks++; if (alu !== 8'h10) begin errors++; $display("FAIL shr got=%h exp=10", alu); end
    checks++; if (valu !== {16{8'h02}}) begin errors++; $display("FAIL vshl got=%h exp=0202..", valu); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      int op, vop;
      op  = ($urandom_range(0, 9) == 0) ? $urandom_range(9, 31) : $urandom_range(0, 8);
      vop = ($urandom_range(0, 9) == 0) ? $urandom_range(9, 31) : $urandom_range(0, 8);
      bundle = 20'($urandom);
      bundle[11:7] = 5'(op);
      bundle[6:2]  = 5'(vop);
      srcA = 16'($urandom); srcB = 16'($urandom);
      vA = {$urandom, $urandom, $urandom, $urandom};
      vB = {$urandom, $urandom, $urandom, $urandom};
      rs1 = 5'($urandom); rs2 = 5'($urandom); rd = 5'($urandom);
      wb = 16'($urandom); mem = 8'($urandom);
      wbv = {$urandom, $urandom, $urandom, $urandom};
      memv = {$urandom, $urandom, $urandom, $urandom};
      selA = 3'($urandom); selB = 3'($urandom);
      reset = ($urandom_range(0, 15) == 0);
      step();
      checks++; if (obs_ctrl !== m_bundle[19:1]) begin errors++; $display("FAIL rnd_ctrl n=%0d got=%h exp=%h", n, obs_ctrl, m_bundle[19:1]); end
      checks++; if (srcA_o !== m_srcA || srcB_o !== m_srcB || obs_idx !== m_idx) begin errors++; $display("FAIL rnd_regs n=%0d got=%h/%h/%h exp=%h/%h/%h", n, srcA_o, srcB_o, obs_idx, m_srcA, m_srcB, m_idx); end
      checks++; if (vA_o !== m_vA || vB_o !== m_vB) begin errors++; $display("FAIL rnd_vregs n=%0d got=%h exp=%h", n, vA_o, m_vA); end
      checks++; if (alu_src_B !== ref_fwd(selB, m_srcB, wb, mem)) begin errors++; $display("FAIL rnd_srcB n=%0d got=%h exp=%h", n, alu_src_B, ref_fwd(selB, m_srcB, wb, mem)); end
      checks++; if (alu !== exp_alu()) begin errors++; $display("FAIL rnd_alu n=%0d op=%0d got=%h exp=%h", n, m_bundle[11:7], alu, exp_alu()); end
      checks++; if (valu !== exp_valu()) begin errors++; $display("FAIL rnd_valu n=%0d op=%0d got=%h exp=%h", n, m_bundle[6:2], valu, exp_valu()); end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    zero_inputs();
    test_reset();
    test_basic();
    test_wrap();
    test_forward();
    test_ones_then_reset();
    test_shift();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/execute_stage_core.md
Name: execute_stage_core

Overview:
- Decode/Execute pipeline register plus the execute-stage datapath of the hybrid scalar/vector CPU.
- Latches the decode-stage control bundle, scalar and vector operands and register indices on each clock.
- Selects each operand from the register, the writeback stage or the memory stage (forwarding selects are computed externally).
- Produces the 8-bit scalar ALU result and the 128-bit vector ALU result for the Execute/Memory register.

Parameters:
- none (widths fixed: scalar operand 16 b, ALU datapath 8 b, vector 128 b = 16 lanes x 8 b, register index 5 b)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- nop_mux_output_in  in  20  decode control bundle (layout below)
- srcA_in, srcB_in  in  16 each  scalar operands from decode
- srcA_vector_in, srcB_vector_in  in  128 each  vector operands from decode
- rs1_decode, rs2_decode, rd_decode  in  5 each  register indices
- select_forward_mux_A, select_forward_mux_B  in  3 each  forwarding selects
- writeback_data  in  16  scalar writeback-stage value
- alu_result_memory  in  8  scalar memory-stage ALU result
- writeback_vector  in  128  vector writeback-stage value
- alu_vector_result_memory  in  128  vector memory-stage ALU result
- wre_execute, vector_wre_execute  out  1 each  registered scalar/vector register-file write enables
- write_memory_enable_a_execute, write_memory_enable_b_execute  out  1 each  registered memory write enables
- select_writeback_data_mux_execute, select_writeback_vector_data_mux_execute  out  2 each  registered writeback selects
- aluOp_execute, aluVectorOp_execute  out  5 each  registered ALU opcodes
- load_instruction  out  1  registered load flag
- srcA_out, srcB_out  out  16 each  registered scalar operands
- srcA_vector_out, srcB_vector_out  out  128 each  registered vector operands
- rs1_execute, rs2_execute, rd_execute  out  5 each  registered indices
- alu_src_B  out  16  forwarded scalar B operand (store data)
- alu_result_execute  out  8  scalar ALU result
- alu_vector_result_execute  out  128  vector ALU result

Behaviour:
- Control bundle layout:
  - [19] wre, [18] vector_wre
  - [17] wme_a, [16] wme_b
  - [15:14] sel_wb, [13:12] sel_wb_vec
  - [11:7] aluOp, [6:2] aluVectorOp
  - [1] load_instruction, [0] reserved (ignored)
- Register update:
  - On each rising clk with reset=1, every registered output is cleared to 0.
  - Otherwise every registered output takes its decode input; latency is 1 cycle.
  - There is no enable or stall input. A bubble is injected by driving a zero bundle.
- Forwarding muxes (combinational), identical for scalar A/B and vector A/B:
  - select 0: registered operand
  - select 1: writeback value
  - select 2: memory-stage result (scalar alu_result_memory zero-extended to 16 b)
  - select 3..7: registered operand
- Scalar ALU (combinational): operands are the forwarded A[7:0] and B[7:0]; result is 8 b and wraps modulo 256.
  - 0 ADD, 1 SUB (A-B)
  - 2 AND, 3 OR, 4 XOR
  - 5 SHL (A << B[2:0]), 6 SHR logical (A >> B[2:0])
  - 7 pass A, 8 pass B
  - others -> 0
- Vector ALU (combinational): applies the same opcode encoding independently per 8-bit lane i (bits 8i+7:8i).
  - No carry or borrow crosses lanes.
  - Shift amounts come from the corresponding B lane [2:0].
  - Undefined opcodes -> all zero.
- After reset all operands and opcodes are 0, so:
  - with both selects 0: alu_result_execute=0 and alu_vector_result_execute=0
  - alu_src_B = 0
- A reset asserted mid-stream discards the in-flight instruction at that edge. Combinational outputs follow the cleared register immediately after the edge.

Test Plan:
- Reset held 1 cycle, then deasserted with all inputs 0 -> all registered outputs 0, alu_result_execute=0, alu_vector_result_execute=0.
- Bundle=0, srcA_in=1, srcB_in=2, vectors A=1 and B=1, rs1/rs2/rd=1/2/3, selects 0 -> after one edge: srcA_out=1, srcB_out=2, rd_execute=3, alu_result_execute=3, alu_vector_result_execute=128'h2, alu_src_B=2.
- aluOp=1, A=0x05, B=0x07 -> alu_result_execute=0xFE (wrap). Vector ADD with every lane 0xFF + 0x01 -> all lanes 0x00, with no carry into neighbouring lanes.
- select_forward_mux_A=2, alu_result_memory=0x10, srcA=1, srcB=2, ADD -> alu_result_execute=0x12. select_forward_mux_B=1 with writeback_data=0x0040 -> alu_src_B=0x0040.
- Bundle 20'hFFFFE latched -> wre/vector_wre/wme_a/wme_b=1, both writeback selects=3, aluOp=aluVectorOp=31, load_instruction=1, and both ALU results=0. Assert reset on the next edge -> all outputs 0.
- Vector SHL with lane A=0x81 and lane B=0x01 -> lane result 0x02. Scalar SHR with A=0x80, B=0x0B (shift 3) -> 0x10.
